edge_event_logger: RTL and testbench
====================================

Name: edge_event_logger

Overview:
- Cycle-sampled event monitor that produces in RTL the same information the team's SVA sampled-value checks compute ($fell/$rose on a 1-bit strobe, change on a narrow bus).
- Each clock edge it samples a 1-bit strobe and a BW-bit bus, then detects rise, fall and bus-change events.
- Events are packed with a cycle timestamp into records and queued in a small FIFO drained by a valid/ready consumer.
- Sits directly downstream of the stimulus under check; the bench's SVA checks and the log records can be cross-compared.

Parameters:
- BW, 4, width of monitored bus sig_b.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- OVF_W, 8, width of saturating dropped-event counter.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sig_a  in  1  monitored strobe.
- sig_b  in  BW  monitored bus.
- ev_valid  out  1  FIFO head record valid.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_ts  out  TS_W  head record timestamp.
- ev_flags  out  3  head record flags {a_rose, a_fell, b_chg}.
- ev_b  out  BW  head record bus value after the change.
- ev_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf_cnt  out  OVF_W  dropped-event count, saturating.
- clr_ovf  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (async assert, sync release): all state is 0. ev_valid=0, ev_ts=0, ev_flags=0, ev_b=0, ev_count=0, ovf_cnt=0, ts=0, warm=0.
- Timestamp: ts increments every cycle out of reset and wraps from 2^TS_W-1 to 0 with no flag.
- Stage 1 (capture), at edge k:
  - cur_a <= sig_a, cur_b <= sig_b, cur_ts <= ts.
  - warm <= 1.
  - prev <= cur.
- Stage 2 (detect), combinational on cur/prev, valid only when a warm history exists. The first captured sample after reset never produces an event.
  - a_rose = !prev_a & cur_a.
  - a_fell = prev_a & !cur_a.
  - b_chg = (prev_b != cur_b).
- Push rule:
  - Push occurs at the edge after capture if any flag is set.
  - Record = {cur_ts, flags, cur_b}, width TS_W+3+BW.
  - All events of one cycle share one record, so at most one push per cycle.
- Latency: an input change sampled at edge k is pushed at edge k+1. If the FIFO was empty, ev_valid=1 after edge k+1, and ev_ts equals the ts value present at edge k.
- FIFO:
  - Show-ahead; head fields are stable while ev_valid=1 and ev_ready=0.
  - Pop when ev_valid & ev_ready.
  - Push accepted when not full, or when full with a pop in the same cycle; occupancy is then unchanged.
  - Push when full with no pop: record dropped, FIFO unchanged, ovf_cnt increments and saturates at 2^OVF_W-1.
  - Pointers wrap modulo DEPTH. ev_count ranges 0..DEPTH.
- clr_ovf: clears ovf_cnt next edge. If clr_ovf coincides with a drop, the result is 0 (clear wins).
- Reset mid-operation: FIFO contents are discarded, pointers and count return to 0, and warm=0, so no spurious event is generated on the first sample after release.
- X/Z on inputs is not filtered and is the bench's responsibility.

Decomposition:
- Shared package edge_log_pkg:
  - typedef ev_flags_t, a packed struct {a_rose, a_fell, b_chg}.
  - Parameterised record width function.
  - localparams FLAG_ROSE=2, FLAG_FELL=1, FLAG_BCHG=0 (bit positions).
- One sub-module: edge_log_fifo, a generic synchronous show-ahead FIFO with DW and DEPTH parameters, push/pop/full/empty/count ports, and async active-low reset.

Test Plan:
- Reset release with sig_a=1 and sig_b=4'h4 held constant -> no record ever; ev_valid stays 0; ts advances by 1 per cycle.
- sig_a 0->1 sampled at ts=5, ev_ready=1 -> ev_valid one cycle later with ev_ts=5, ev_flags=3'b100, ev_b=4'h4; FIFO empty the next cycle.
- sig_a 1->0 and sig_b 4'h5->4'h0 in the same sample at ts=9 -> single record with ev_flags=3'b011, ev_b=4'h0, ev_ts=9.
- ev_ready=0 and sig_b toggling 4'h4/4'h5 every cycle for 12 cycles -> ev_count saturates at 8, ovf_cnt=4, the first 8 records are intact in order, head is stable throughout.
- FIFO full, then a cycle with simultaneous push and pop -> ev_count stays 8, ovf_cnt unchanged, new record is appended at the tail.
- Assert rst_n mid-stream with 3 records queued -> ev_valid=0 and ev_count=0 immediately (async); after release, a first sample with sig_a=1 yields no rose event.

Source files
------------

// File: rtl/edge_log_pkg.sv
// Shared definitions for the edge event logger.
//   ev_flags_t  : event flag bundle {a_rose, a_fell, b_chg}
//   FLAG_*      : bit positions of each flag inside a 3-bit flag field
//   rec_width() : width of one queued record {timestamp, flags, bus value}
package edge_log_pkg;

  localparam int FLAG_ROSE = 2;
  localparam int FLAG_FELL = 1;
  localparam int FLAG_BCHG = 0;

  typedef struct packed {
    logic a_rose;
    logic a_fell;
    logic b_chg;
  } ev_flags_t;

  function automatic int rec_width(input int ts_w, input int bw);
    return ts_w + 3 + bw;
  endfunction

endpackage

// File: rtl/edge_log_fifo.sv
// Generic synchronous show-ahead FIFO.
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write request and data; ignored when full unless popping too
//   pop        : read request; ignored when empty
//   rdata      : head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module edge_log_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_event_logger.sv
// Cycle-sampled edge/change monitor with a timestamped event queue.
//   clk, rst_n : clock and asynchronous active-low reset
//   sig_a      : monitored strobe (rise/fall detection)
//   sig_b      : monitored BW-bit bus (change detection)
//   ev_valid   : head record present
//   ev_ready   : consumer takes the head record this cycle
//   ev_ts      : head record timestamp (ts at the sampling edge)
//   ev_flags   : head record flags {a_rose, a_fell, b_chg}
//   ev_b       : head record bus value after the change
//   ev_count   : queue occupancy
//   ovf_cnt    : saturating count of records dropped on a full queue
//   clr_ovf    : synchronous clear of ovf_cnt
module edge_event_logger
  import edge_log_pkg::*;
#(
  parameter int BW    = 4,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int OVF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sig_a,
  input  logic [BW-1:0]            sig_b,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [2:0]               ev_flags,
  output logic [BW-1:0]            ev_b,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [OVF_W-1:0]         ovf_cnt,
  input  logic                     clr_ovf
);

  localparam int RW = rec_width(TS_W, BW);

  logic [TS_W-1:0] ts;
  logic            cur_a;
  logic [BW-1:0]   cur_b;
  logic [TS_W-1:0] cur_ts;
  logic            prev_a;
  logic [BW-1:0]   prev_b;
  logic            warm;
  logic            hist;
  ev_flags_t       flags;
  logic            any_ev;
  logic            pop;
  logic            full;
  logic            empty;
  logic [RW-1:0]   wdata;
  logic [RW-1:0]   rdata;
  logic            drop;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // warm marks that cur holds a real sample; hist marks that prev does too.
  // Detection needs both, so the first sample after reset never compares
  // against the reset value of prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_a  <= 1'b0;
      cur_b  <= '0;
      cur_ts <= '0;
      prev_a <= 1'b0;
      prev_b <= '0;
      warm   <= 1'b0;
      hist   <= 1'b0;
    end else begin
      cur_a  <= sig_a;
      cur_b  <= sig_b;
      cur_ts <= ts;
      prev_a <= cur_a;
      prev_b <= cur_b;
      warm   <= 1'b1;
      hist   <= warm;
    end
  end

  always_comb begin
    flags = '0;
    if (hist) begin
      flags.a_rose = ~prev_a & cur_a;
      flags.a_fell = prev_a & ~cur_a;
      flags.b_chg  = (prev_b != cur_b);
    end
  end

  // All events seen in one sample share a single record.
  assign any_ev = flags.a_rose | flags.a_fell | flags.b_chg;
  assign wdata  = {cur_ts, flags, cur_b};
  assign pop    = ev_valid & ev_ready;
  assign drop   = any_ev & full & ~pop;

  edge_log_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (any_ev),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (ev_count)
  );

  assign ev_valid = ~empty;

  always_comb begin
    ev_ts              = rdata[RW-1 -: TS_W];
    ev_flags           = '0;
    ev_flags[FLAG_ROSE] = rdata[BW + FLAG_ROSE];
    ev_flags[FLAG_FELL] = rdata[BW + FLAG_FELL];
    ev_flags[FLAG_BCHG] = rdata[BW + FLAG_BCHG];
    ev_b               = rdata[BW-1:0];
  end

  // A clear takes priority over a simultaneous drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_ovf) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != {OVF_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_edge_event_logger.sv
// Directed self-checking bench for edge_event_logger (default parameters).
// Inputs change one time unit after a rising edge and are checked there.
module tb_edge_event_logger;

  logic        clk;
  logic        rst_n;
  logic        sig_a;
  logic [3:0]  sig_b;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_ts;
  logic [2:0]  ev_flags;
  logic [3:0]  ev_b;
  logic [3:0]  ev_count;
  logic [7:0]  ovf_cnt;
  logic        clr_ovf;

  int checks;
  int failures;

  typedef struct {
    logic        a;
    logic [3:0]  b;
    logic        rdy;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_ts;
    logic [2:0]  exp_flags;
    logic [3:0]  exp_b;
    int          exp_count;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  edge_event_logger dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_a    (sig_a),
    .sig_b    (sig_b),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ts    (ev_ts),
    .ev_flags (ev_flags),
    .ev_b     (ev_b),
    .ev_count (ev_count),
    .ovf_cnt  (ovf_cnt),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic a, input logic [3:0] b, input logic rdy,
                                 input logic clr, input logic ev, input logic [15:0] ts,
                                 input logic [2:0] fl, input logic [3:0] eb,
                                 input int cnt, input int ovf);
    vec_t v;
    v.a = a; v.b = b; v.rdy = rdy; v.clr = clr;
    v.exp_valid = ev; v.exp_ts = ts; v.exp_flags = fl; v.exp_b = eb;
    v.exp_count = cnt; v.exp_ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic [3:0] b, input logic rdy, input logic clr);
    sig_a    = a;
    sig_b    = b;
    ev_ready = rdy;
    clr_ovf  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkVal($sformatf("v%0d.valid", idx), 32'(ev_valid), 32'(v.exp_valid));
    checkVal($sformatf("v%0d.count", idx), 32'(ev_count), v.exp_count);
    checkVal($sformatf("v%0d.ovf", idx), 32'(ovf_cnt), v.exp_ovf);
    if (v.exp_valid) begin
      checkVal($sformatf("v%0d.ts", idx), 32'(ev_ts), 32'(v.exp_ts));
      checkVal($sformatf("v%0d.flags", idx), 32'(ev_flags), 32'(v.exp_flags));
      checkVal($sformatf("v%0d.b", idx), 32'(ev_b), 32'(v.exp_b));
    end
  endtask

  task automatic doReset(input logic a, input logic [3:0] b);
    rst_n    = 1'b0;
    sig_a    = a;
    sig_b    = b;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] nb;
    checks   = 0;
    failures = 0;

    // Sample k after release is taken with ts == k.
    for (int i = 0; i < 5; i++) addVec(0, 4'h4, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 4'h4, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 4'h4, 1, 0, 1, 16'd5, 3'b100, 4'h4, 1, 0);
    addVec(1, 4'h5, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 4'h5, 1, 0, 1, 16'd7, 3'b001, 4'h5, 1, 0);
    addVec(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 4'h0, 0, 0, 1, 16'd9, 3'b011, 4'h0, 1, 0);
    addVec(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Bus toggles with the consumer stalled: samples 12..23 each make a record.
    for (int k = 12; k <= 24; k++) begin
      addVec(0, (k == 24 || (k % 2) == 1) ? 4'h5 : 4'h4, 0, 0, (k >= 13), 16'd12, 3'b001, 4'h4,
             (k - 12 > 8) ? 8 : k - 12, (k > 20) ? k - 20 : 0);
    end
    addVec(0, 4'h4, 0, 0, 1, 16'd12, 3'b001, 4'h4, 8, 4);
    // Full queue: push of record ts=25 coincides with pop of ts=12.
    addVec(0, 4'h4, 1, 0, 1, 16'd13, 3'b001, 4'h5, 8, 4);
    for (int j = 1; j <= 6; j++) begin
      addVec(0, 4'h4, 1, 0, 1, 16'(13 + j), 3'b001, ((13 + j) % 2 == 1) ? 4'h5 : 4'h4, 8 - j, 4);
    end
    addVec(0, 4'h4, 1, 0, 1, 16'd25, 3'b001, 4'h4, 1, 4);
    addVec(0, 4'h4, 1, 0, 0, 0, 0, 0, 0, 4);
    addVec(0, 4'h4, 1, 1, 0, 0, 0, 0, 0, 0);

    // Reset state, then constant inputs must never produce a record.
    rst_n = 1'b0; sig_a = 1'b1; sig_b = 4'h4; ev_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst.valid", 32'(ev_valid), 0);
    checkVal("rst.count", 32'(ev_count), 0);
    checkVal("rst.ovf", 32'(ovf_cnt), 0);
    checkVal("rst.ts", 32'(ev_ts), 0);
    checkVal("rst.flags", 32'(ev_flags), 0);
    checkVal("rst.b", 32'(ev_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 4'h4, 1, 0);
      checkVal($sformatf("quiet%0d.valid", i), 32'(ev_valid), 0);
      checkVal($sformatf("quiet%0d.count", i), 32'(ev_count), 0);
    end

    // Table-driven main run from a fresh reset.
    doReset(0, 4'h4);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rdy, vecs[i].clr);
      checkOutput(i, vecs[i]);
    end

    // Long stall: the drop counter must saturate, then a clear wins over a drop.
    nb = 4'h4;
    for (int i = 0; i < 275; i++) begin
      nb = (nb == 4'h4) ? 4'h5 : 4'h4;
      applyStimulus(0, nb, 0, 0);
    end
    checkVal("sat.ovf", 32'(ovf_cnt), 32'd255);
    checkVal("sat.count", 32'(ev_count), 32'd8);
    nb = (nb == 4'h4) ? 4'h5 : 4'h4;
    applyStimulus(0, nb, 0, 0);
    checkVal("sat.hold", 32'(ovf_cnt), 32'd255);
    nb = (nb == 4'h4) ? 4'h5 : 4'h4;
    applyStimulus(0, nb, 0, 1);
    checkVal("clr.ovf", 32'(ovf_cnt), 0);
    nb = (nb == 4'h4) ? 4'h5 : 4'h4;
    applyStimulus(0, nb, 0, 0);
    checkVal("clr.next", 32'(ovf_cnt), 32'd1);

    // Three records queued, then an asynchronous reset mid-cycle.
    doReset(0, 4'h0);
    applyStimulus(0, 4'h0, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);
    applyStimulus(0, 4'h1, 0, 0);
    applyStimulus(0, 4'h2, 0, 0);
    applyStimulus(0, 4'h3, 0, 0);
    applyStimulus(0, 4'h3, 0, 0);
    applyStimulus(0, 4'h3, 0, 0);
    checkVal("mid.count", 32'(ev_count), 32'd3);
    checkVal("mid.ts", 32'(ev_ts), 32'd2);
    checkVal("mid.b", 32'(ev_b), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async.valid", 32'(ev_valid), 0);
    checkVal("async.count", 32'(ev_count), 0);
    sig_a = 1'b1;
    sig_b = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'h0, 0, 0);
      checkVal($sformatf("post%0d.valid", i), 32'(ev_valid), 0);
      checkVal($sformatf("post%0d.count", i), 32'(ev_count), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
